// File: rtl/pipelined_fu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_fu_pkg
// Description : Shared types for the pipelined functional unit: the operation
//               mode encoding and the 6-bit serial configuration word.
// Revision    : 1.0 - initial release
// ============================================================================
package pipelined_fu_pkg;

    localparam int FU_CFG_W = 6;

    // Codes 13..15 are unused and behave as pass_a.
    typedef enum logic [3:0] {
        FU_ADD    = 4'd0,
        FU_SUB    = 4'd1,
        FU_PASS_A = 4'd2,
        FU_PASS_B = 4'd3,
        FU_AND    = 4'd4,
        FU_OR     = 4'd5,
        FU_XOR    = 4'd6,
        FU_NOT_A  = 4'd7,
        FU_SHL    = 4'd8,
        FU_SHR    = 4'd9,
        FU_MIN    = 4'd10,
        FU_MAX    = 4'd11,
        FU_ACC    = 4'd12
    } fu_mode_e;

    // MSB to LSB: mode[3:0], saturate, is_signed.
    typedef struct packed {
        fu_mode_e mode;
        logic     saturate;
        logic     is_signed;
    } fu_cfg_t;

endpackage
`default_nettype wire

// File: rtl/pipelined_fu_alu.sv
`default_nettype none
// ============================================================================
// Module      : fu_alu
// Description : Combinational compute of the functional unit.
//   a_i, b_i  : operands
//   cfg_i     : configuration word {mode, saturate, is_signed}
//   acc_i     : current accumulator value (used by acc mode)
//   result_o  : result (saturated where enabled); in acc mode, the new acc
//   flags_o   : {overflow, carry, zero}
// Revision    : 1.0 - initial release
// ============================================================================
module fu_alu
    import pipelined_fu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [FU_CFG_W-1:0] cfg_i,
    input  logic [WIDTH-1:0]    acc_i,
    output logic [WIDTH-1:0]    result_o,
    output logic [2:0]          flags_o
);

    localparam logic [WIDTH-1:0] c_umax = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};

    fu_cfg_t              w_cfg;
    logic [WIDTH-1:0]     w_x;
    logic [WIDTH-1:0]     w_y;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic                 w_sum_ov;
    logic                 w_diff_ov;
    logic                 w_lt;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]     w_res;
    logic                 w_carry;
    logic                 w_ov;

    assign w_cfg   = fu_cfg_t'(cfg_i);
    assign w_shamt = b_i[SHAMT_W-1:0];

    // add and acc share one adder; acc adds a_i onto the accumulator.
    assign w_x    = (w_cfg.mode == FU_ACC) ? acc_i : a_i;
    assign w_y    = (w_cfg.mode == FU_ACC) ? a_i   : b_i;
    assign w_sum  = {1'b0, w_x} + {1'b0, w_y};
    assign w_diff = {1'b0, a_i} - {1'b0, b_i};

    // Signed overflow: result sign disagrees with what the operand signs allow.
    assign w_sum_ov  = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    assign w_diff_ov = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);

    assign w_lt = w_cfg.is_signed ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

    always_comb begin
        w_res   = a_i;
        w_carry = 1'b0;
        w_ov    = 1'b0;
        case (w_cfg.mode)
            FU_ADD, FU_ACC: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ov    = w_sum_ov;
                // A signed overflow always goes in the direction of the
                // first operand's sign, since both operands share it.
                if (w_cfg.saturate) begin
                    if (w_cfg.is_signed) begin
                        if (w_sum_ov) w_res = w_x[WIDTH-1] ? c_smin : c_smax;
                    end else if (w_sum[WIDTH]) begin
                        w_res = c_umax;
                    end
                end
            end
            FU_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ov    = w_diff_ov;
                if (w_cfg.saturate) begin
                    if (w_cfg.is_signed) begin
                        if (w_diff_ov) w_res = a_i[WIDTH-1] ? c_smin : c_smax;
                    end else if (w_diff[WIDTH]) begin
                        w_res = '0;
                    end
                end
            end
            FU_PASS_A: w_res = a_i;
            FU_PASS_B: w_res = b_i;
            FU_AND:    w_res = a_i & b_i;
            FU_OR:     w_res = a_i | b_i;
            FU_XOR:    w_res = a_i ^ b_i;
            FU_NOT_A:  w_res = ~a_i;
            FU_SHL:    w_res = a_i << w_shamt;
            FU_SHR:    w_res = w_cfg.is_signed ? ($signed(a_i) >>> w_shamt) : (a_i >> w_shamt);
            FU_MIN:    w_res = w_lt ? a_i : b_i;
            FU_MAX:    w_res = w_lt ? b_i : a_i;
            default:   w_res = a_i;
        endcase
    end

    assign result_o = w_res;
    assign flags_o  = {w_ov, w_carry, (w_res == '0)};

endmodule
`default_nettype wire

// File: rtl/pipelined_fu.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_fu
// Description : Two-stage pipelined functional unit with valid/ready
//               handshakes and a daisy-chainable serial configuration port.
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   program_en_i / program_data_i     : serial config shift enable / data in
//   program_data_o                    : serial config data out to next unit
//   in_valid_i / in_ready_o, a_i, b_i : operand pair handshake
//   out_valid_o / out_ready_i         : result handshake
//   result_o, flags_o                 : result, {overflow, carry, zero}
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_fu
    import pipelined_fu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             program_en_i,
    input  logic             program_data_i,
    output logic             program_data_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [2:0]       flags_o
);

    // Configuration chain
    logic [FU_CFG_W-1:0] r_shift;
    logic                r_prog_out;
    logic                r_prog_en_d;
    fu_cfg_t             r_cfg;
    logic                w_cfg_load;
    fu_cfg_t             w_cfg_eff;

    // Pipeline
    logic                r_s1_valid;
    logic [WIDTH-1:0]    r_s1_a;
    logic [WIDTH-1:0]    r_s1_b;
    fu_cfg_t             r_s1_cfg;
    logic                r_s2_valid;
    logic [WIDTH-1:0]    r_result;
    logic [2:0]          r_flags;
    logic [WIDTH-1:0]    r_acc;

    logic                w_s2_free;
    logic                w_accept;
    logic                w_s1_adv;
    logic [WIDTH-1:0]    w_alu_res;
    logic [2:0]          w_alu_flags;

    assign w_s2_free  = !r_s2_valid || out_ready_i;
    assign in_ready_o = !program_en_i && (!r_s1_valid || w_s2_free);
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_s1_adv   = r_s1_valid && w_s2_free;

    // The config loads on the first cycle with program_en_i low after a
    // shift burst. An operand accepted in that same cycle picks up the new
    // config directly, so it never runs with the configuration being replaced.
    assign w_cfg_load = r_prog_en_d && !program_en_i;
    assign w_cfg_eff  = w_cfg_load ? fu_cfg_t'(r_shift) : r_cfg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shift     <= '0;
            r_prog_out  <= 1'b0;
            r_prog_en_d <= 1'b0;
            r_cfg       <= '0;
        end else begin
            r_prog_en_d <= program_en_i;
            if (program_en_i) begin
                r_shift    <= {r_shift[FU_CFG_W-2:0], program_data_i};
                r_prog_out <= r_shift[FU_CFG_W-1];
            end
            if (w_cfg_load) r_cfg <= fu_cfg_t'(r_shift);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cfg   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= a_i;
            r_s1_b     <= b_i;
            r_s1_cfg   <= w_cfg_eff;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2 only changes when it can take a new item, which keeps the
    // result and flags stable under backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_alu_res;
                r_flags  <= w_alu_flags;
            end
        end
    end

    // The clear on config load wins over an acc item entering stage 2 in
    // the same cycle; that item still reports the value computed from the
    // old accumulator.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc <= '0;
        end else if (w_cfg_load) begin
            r_acc <= '0;
        end else if (w_s1_adv && (r_s1_cfg.mode == FU_ACC)) begin
            r_acc <= w_alu_res;
        end
    end

    fu_alu #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .a_i      (r_s1_a),
        .b_i      (r_s1_b),
        .cfg_i    (r_s1_cfg),
        .acc_i    (r_acc),
        .result_o (w_alu_res),
        .flags_o  (w_alu_flags)
    );

    assign program_data_o = r_prog_out;
    assign out_valid_o    = r_s2_valid;
    assign result_o       = r_result;
    assign flags_o        = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_fu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_fu
// Description : Self-checking bench for pipelined_fu (WIDTH=8). Two units are
//               chained on the config port; unit 0 carries the traffic and
//               is checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_fu;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             pen;
    logic             pdata;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             pdo0, in_ready0, out_valid0;
    logic [WIDTH-1:0] result0;
    logic [2:0]       flags0;

    logic             in_valid1;
    logic             pdo1, in_ready1, out_valid1;
    logic [WIDTH-1:0] result1;
    logic [2:0]       flags1;

    pipelined_fu #(.WIDTH(WIDTH)) u0 (
        .clk_i(clk), .rst_i(rst), .program_en_i(pen), .program_data_i(pdata),
        .program_data_o(pdo0), .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .a_i(a), .b_i(b), .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .result_o(result0), .flags_o(flags0)
    );

    pipelined_fu #(.WIDTH(WIDTH)) u1 (
        .clk_i(clk), .rst_i(rst), .program_en_i(pen), .program_data_i(pdo0),
        .program_data_o(pdo1), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .a_i(a), .b_i(b), .out_valid_o(out_valid1), .out_ready_i(1'b1),
        .result_o(result1), .flags_o(flags1)
    );

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    typedef struct {
        int         res;
        logic [2:0] fl;
    } exp_t;
    exp_t       q[$];
    int         acc_m  = 0;
    logic [5:0] cfg0_m = 6'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int to_s(input int u);
        return (u >= 128) ? u - 256 : u;
    endfunction

    // Reference model: plain integer arithmetic on unsigned and signed views.
    function automatic void ref_op(input logic [5:0] cfg, input int ua, input int ub,
                                   input int acc_in, output int res, output logic [2:0] fl);
        int  mode, sh, x, y, ssum, sdiff;
        bit  sat, sgn, c, v;
        mode = int'(cfg[5:2]);
        sat  = cfg[1];
        sgn  = cfg[0];
        sh   = ub % 8;
        c    = 0;
        v    = 0;
        case (mode)
            0, 12: begin
                x    = (mode == 12) ? acc_in : ua;
                y    = (mode == 12) ? ua : ub;
                ssum = to_s(x) + to_s(y);
                c    = (x + y) > 255;
                v    = (ssum > 127) || (ssum < -128);
                res  = (x + y) & 255;
                if (sat && sgn) begin
                    if (ssum > 127) res = 127;
                    else if (ssum < -128) res = 128;
                end else if (sat && c) begin
                    res = 255;
                end
            end
            1: begin
                sdiff = to_s(ua) - to_s(ub);
                c     = ua < ub;
                v     = (sdiff > 127) || (sdiff < -128);
                res   = (ua - ub) & 255;
                if (sat && sgn) begin
                    if (sdiff > 127) res = 127;
                    else if (sdiff < -128) res = 128;
                end else if (sat && c) begin
                    res = 0;
                end
            end
            3:  res = ub;
            4:  res = ua & ub;
            5:  res = ua | ub;
            6:  res = ua ^ ub;
            7:  res = 255 - ua;
            8:  res = (ua << sh) & 255;
            9:  res = sgn ? ((to_s(ua) >>> sh) & 255) : (ua >> sh);
            10: res = (sgn ? (to_s(ua) < to_s(ub)) : (ua < ub)) ? ua : ub;
            11: res = (sgn ? (to_s(ua) < to_s(ub)) : (ua < ub)) ? ub : ua;
            default: res = ua;
        endcase
        fl = {v, c, (res == 0)};
    endfunction

    // Scoreboard: log accepted pairs, compare delivered results in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid0 && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("spurious_output", 32'(out_valid0), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_result", 32'(result0), 32'(e.res));
                    chk("sb_flags", 32'(flags0), 32'(e.fl));
                end
            end
            if (in_valid && in_ready0) begin
                exp_t e;
                ref_op(cfg0_m, int'(a), int'(b), acc_m, e.res, e.fl);
                if (cfg0_m[5:2] == 4'd12) acc_m = e.res;
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shifts c1 then a pad bit then c0: the output register of unit 0 adds
    // one stage, so unit 1 needs 7 shifts to see a bit that unit 0 got.
    task automatic program2(input logic [5:0] c0, input logic [5:0] c1);
        logic [12:0] s;
        s        = {c1, 1'b0, c0};
        in_valid = 1'b0;
        pen      = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            pdata = s[12-j];
            step();
            chk("prog_ready_low", 32'(in_ready0), 32'd0);
            if (j >= 6) chk("prog_delay6", 32'(pdo0), 32'(s[12-(j-6)]));
        end
        pen    = 1'b0;
        pdata  = 1'b0;
        cfg0_m = c0;
        acc_m  = 0;
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((q.size() != 0 || out_valid0) && k < 20) begin
            step();
            k++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    // One pair into an empty pipe with exact 2-cycle latency check.
    task automatic send_one(input logic [7:0] aa, input logic [7:0] bb,
                            input int exp_res, input logic [2:0] exp_fl, input string tag);
        a         = aa;
        b         = bb;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        chk({tag, "_ready"}, 32'(in_ready0), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid0), 32'd0);
        step();
        chk({tag, "_lat2"}, 32'(out_valid0), 32'd1);
        chk({tag, "_res"}, 32'(result0), 32'(exp_res));
        chk({tag, "_flags"}, 32'(flags0), 32'(exp_fl));
        step();
    endtask

    initial begin
        int n0, res;
        logic [2:0] fl;
        logic [7:0] pa[3];
        logic [7:0] pb[3];

        rst = 1'b1; pen = 1'b0; pdata = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
        out_ready = 1'b1; a = '0; b = '0;
        step(); step(); step();
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_result", 32'(result0), 32'd0);
        chk("rst_flags", 32'(flags0), 32'd0);
        chk("rst_pdo", 32'(pdo0), 32'd0);
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready0), 32'd1);

        // Reset config is add/unsigned/no-sat.
        send_one(8'd200, 8'd100, 44, 3'b010, "add_default");
        program2(6'b0000_00, 6'b0000_00);
        step();
        send_one(8'd200, 8'd100, 44, 3'b010, "add_prog");

        program2({4'd1, 1'b1, 1'b1}, 6'd0);
        step();
        send_one(8'h80, 8'h01, 8'h80, 3'b100, "sub_ssat");
        program2({4'd0, 1'b1, 1'b0}, 6'd0);
        step();
        send_one(8'd200, 8'd100, 255, 3'b010, "add_usat");

        // Backpressure: two held, third waits, order preserved.
        program2(6'd0, 6'd0);
        step();
        pa = '{8'd1, 8'd3, 8'd5};
        pb = '{8'd2, 8'd4, 8'd6};
        n0 = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = pa[0]; b = pb[0];
        chk("bp_rdy0", 32'(in_ready0), 32'd1);
        step();
        a = pa[1]; b = pb[1];
        chk("bp_rdy1", 32'(in_ready0), 32'd1);
        step();
        a = pa[2]; b = pb[2];
        chk("bp_rdy2", 32'(in_ready0), 32'd0);
        step();
        chk("bp_rdy2_hold", 32'(in_ready0), 32'd0);
        chk("bp_stable", 32'(result0), 32'd3);
        step();
        chk("bp_stable2", 32'(result0), 32'd3);
        out_ready = 1'b1;
        step();
        drain();
        chk("bp_count", 32'(n_out - n0), 32'd3);

        // Accumulator, and clear on reprogramming.
        program2({4'd12, 2'b00}, 6'd0);
        step();
        send_one(8'd10, 8'd0, 10, 3'b000, "acc1");
        send_one(8'd20, 8'd0, 30, 3'b000, "acc2");
        send_one(8'd30, 8'd0, 60, 3'b000, "acc3");
        program2({4'd12, 2'b00}, 6'd0);
        step();
        send_one(8'd5, 8'd0, 5, 3'b000, "acc_clr");

        // In-flight items finish with their old config while reprogramming.
        program2(6'd0, 6'd0);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'd50; b = 8'd60;
        step();
        a = 8'd70; b = 8'd80;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        program2({4'd1, 2'b00}, 6'd0);
        chk("inflight_drained", 32'(n_out - n0), 32'd2);
        step();
        send_one(8'd50, 8'd60, 8'hF6, 3'b010, "sub_after");

        // Chain: unit 0 xor, unit 1 signed sub, both loaded together.
        program2({4'd6, 2'b00}, {4'd1, 2'b01});
        step();
        send_one(8'h5A, 8'h0F, 8'h55, 3'b000, "chain_u0");
        a = 8'h10; b = 8'h20; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        step();
        chk("chain_u1_valid", 32'(out_valid1), 32'd1);
        chk("chain_u1_res", 32'(result1), 32'hF0);
        chk("chain_u1_flags", 32'(flags1), 32'(3'b010));
        step();

        // Randomised traffic over random configs.
        for (int blk = 0; blk < 8; blk++) begin
            drain();
            program2(6'($urandom), 6'($urandom));
            for (int c = 0; c < 40; c++) begin
                a         = 8'($urandom);
                b         = 8'($urandom);
                in_valid  = ($urandom % 4) != 0;
                out_ready = ($urandom % 4) != 0;
                step();
            end
        end
        drain();

        // Reset with two items in flight.
        program2({4'd1, 2'b00}, 6'd0);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'd9; b = 8'd4;
        step(); step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("rst2_out_valid", 32'(out_valid0), 32'd0);
        chk("rst2_result", 32'(result0), 32'd0);
        chk("rst2_flags", 32'(flags0), 32'd0);
        q.delete();
        acc_m  = 0;
        cfg0_m = 6'd0;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rst2_ready", 32'(in_ready0), 32'd1);
        n0 = n_out;
        step(); step(); step();
        chk("rst2_no_stale", 32'(n_out - n0), 32'd0);
        ref_op(6'd0, 7, 9, 0, res, fl);
        send_one(8'd7, 8'd9, 16, 3'b000, "rst2_add");
        chk("rst2_model", 32'(res), 32'd16);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
